// File: rtl/debouncer_array.sv
// debouncer_array: per-channel button synchroniser, tick-sampled debounce filter,
// press/release strobes and auto-repeat, sharing one sample-tick divider.
module debouncer_array #(
   parameter int CHANNELS     = 4,
   parameter int TICK_DIV     = 1000000,
   parameter int STABLE_TICKS = 3,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10,
   parameter bit ACTIVE_LOW   = 0
) (
   input  logic                i_clock,
   input  logic                i_reset_n,
   input  logic [CHANNELS-1:0] i_buttons,
   output logic [CHANNELS-1:0] o_level,
   output logic [CHANNELS-1:0] o_press,
   output logic [CHANNELS-1:0] o_release,
   output logic [CHANNELS-1:0] o_repeat
);
   localparam int CW   = $clog2(TICK_DIV);
   localparam int SW   = $clog2(STABLE_TICKS + 1);
   localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [1:0] IDLE = 2'd0, DELAY = 2'd1, RPT = 2'd2;
   localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
   localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_TICKS - 1);
   localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

   logic [CHANNELS-1:0] meta, sync;
   logic [CW-1:0]       div;
   logic                tick;

   assign tick = div == TICK_LAST;

   always_ff @(posedge i_clock or negedge i_reset_n)
      if (!i_reset_n) begin
         meta <= '0;
         sync <= '0;
         div  <= '0;
      end else begin
         meta <= i_buttons ^ {CHANNELS{ACTIVE_LOW}};
         sync <= meta;
         div  <= tick ? '0 : div + CW'(1);
      end

   for (genvar g = 0; g < CHANNELS; g++) begin : ch
      logic [SW-1:0] stab;
      logic [RW-1:0] rep;
      logic [1:0]    state;
      logic          level, press_q, release_q, repeat_q;
      logic          settle, rise, fall, due;

      // settle marks the tick on which a pending change is finally accepted
      assign settle = tick && sync[g] != level && stab == STAB_LAST;
      assign rise   = settle && !level;
      assign fall   = settle && level;
      assign due    = tick && (state == DELAY ? rep == DELAY_LAST : state == RPT && rep == RATE_LAST);

      always_ff @(posedge i_clock or negedge i_reset_n)
         if (!i_reset_n) begin
            stab      <= '0;
            rep       <= '0;
            state     <= IDLE;
            level     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
         end else begin
            press_q   <= rise;
            release_q <= fall;
            repeat_q  <= due && !fall;
            if (tick) begin
               stab  <= sync[g] == level || settle ? '0 : stab + SW'(1);
               level <= level ^ settle;
               if (fall) begin
                  state <= IDLE;
                  rep   <= '0;
               end else if (rise) begin
                  state <= REPEAT_DELAY == 0 ? IDLE : DELAY;
                  rep   <= '0;
               end else if (state != IDLE) begin
                  state <= due ? RPT : state;
                  rep   <= due ? '0 : rep + RW'(1);
               end
            end
         end

      assign o_level[g]   = level;
      assign o_press[g]   = press_q;
      assign o_release[g] = release_q;
      assign o_repeat[g]  = repeat_q;
   end
endmodule

// File: tb/tb_debouncer_array.sv
// tb_debouncer_array: table-driven segments, hand-written reset/simultaneous sequences
// and random stimulus, all checked every cycle against a tick-counting reference model.
module tb_debouncer_array;
   localparam int CH = 4, TD = 4, ST = 3, RD = 5, RR = 2;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic [3:0] btn_a = 4'h0, btn_b = 4'hF;
   logic [3:0] lvl_a, prs_a, rel_a, rep_a, lvl_b, prs_b, rel_b, rep_b;

   always #5 clk = ~clk;

   debouncer_array #(.CHANNELS(CH), .TICK_DIV(TD), .STABLE_TICKS(ST), .REPEAT_DELAY(RD),
                     .REPEAT_RATE(RR), .ACTIVE_LOW(0)) dut_a (
      .i_clock(clk), .i_reset_n(rst_n), .i_buttons(btn_a),
      .o_level(lvl_a), .o_press(prs_a), .o_release(rel_a), .o_repeat(rep_a));

   debouncer_array #(.CHANNELS(CH), .TICK_DIV(TD), .STABLE_TICKS(ST), .REPEAT_DELAY(RD),
                     .REPEAT_RATE(RR), .ACTIVE_LOW(1)) dut_b (
      .i_clock(clk), .i_reset_n(rst_n), .i_buttons(btn_b),
      .o_level(lvl_b), .o_press(prs_b), .o_release(rel_b), .o_repeat(rep_b));

   int vectors = 0, miscompares = 0;
   int sp, sr, srp;

   // reference model: raw history per edge, tick numbering, press-tick arithmetic
   logic [3:0] hist [2][0:8191];
   int         e, tn;
   logic [3:0] m_lvl [2];
   logic [3:0] x_prs [2], x_rel [2], x_rep [2];
   int         run [2][4], ptick [2][4];

   typedef struct {
      logic [3:0] btn;
      int         cycles;
      logic [3:0] lvl;
      int         prs, rel, rep;
   } seg_t;
   seg_t tbl [13];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      e  = 0;
      tn = 0;
      for (int k = 0; k < 2; k++) begin
         m_lvl[k] = 4'h0;
         x_prs[k] = 4'h0;
         x_rel[k] = 4'h0;
         x_rep[k] = 4'h0;
         for (int c = 0; c < CH; c++) begin
            run[k][c]   = 0;
            ptick[k][c] = 0;
         end
      end
   endtask

   task automatic model_edge();
      logic [3:0] seen;
      bit         tick;
      int         d;
      tick = (e % TD) == TD - 1;
      if (tick) tn++;
      hist[0][e] = btn_a;
      hist[1][e] = ~btn_b;
      for (int k = 0; k < 2; k++) begin
         x_prs[k] = 4'h0;
         x_rel[k] = 4'h0;
         x_rep[k] = 4'h0;
         seen = e >= 2 ? hist[k][e-2] : 4'h0;
         if (tick) begin
            for (int c = 0; c < CH; c++) begin
               run[k][c] = seen[c] != m_lvl[k][c] ? run[k][c] + 1 : 0;
               d = tn - ptick[k][c];
               if (run[k][c] == ST) begin
                  run[k][c]   = 0;
                  m_lvl[k][c] = ~m_lvl[k][c];
                  if (m_lvl[k][c]) begin
                     x_prs[k][c] = 1'b1;
                     ptick[k][c] = tn;
                  end else x_rel[k][c] = 1'b1;
               end else if (m_lvl[k][c] && d >= RD && (d - RD) % RR == 0)
                  x_rep[k][c] = 1'b1;
            end
         end
      end
      e++;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      chk("level_a", lvl_a, m_lvl[0]);
      chk("press_a", prs_a, x_prs[0]);
      chk("release_a", rel_a, x_rel[0]);
      chk("repeat_a", rep_a, x_rep[0]);
      chk("level_b", lvl_b, m_lvl[1]);
      chk("press_b", prs_b, x_prs[1]);
      chk("release_b", rel_b, x_rel[1]);
      chk("repeat_b", rep_b, x_rep[1]);
      sp  += $countones(prs_a);
      sr  += $countones(rel_a);
      srp += $countones(rep_a);
   endtask

   task automatic reset_cycle();
      @(posedge clk);
      #1;
      chk("rst_outs_a", {lvl_a, prs_a, rel_a, rep_a}, 16'h0);
      chk("rst_outs_b", {lvl_b, prs_b, rel_b, rep_b}, 16'h0);
   endtask

   initial begin
      int at, cnt_rel, j;
      logic [3:0] got;
      tbl = '{
         '{4'b0001, 36, 4'b0001, 1, 0, 1},
         '{4'b0000, 16, 4'b0000, 0, 1, 1},
         '{4'b0010,  6, 4'b0000, 0, 0, 0},
         '{4'b0000, 20, 4'b0000, 0, 0, 0},
         '{4'b1000,  3, 4'b0000, 0, 0, 0},
         '{4'b0000,  3, 4'b0000, 0, 0, 0},
         '{4'b1000,  3, 4'b0000, 0, 0, 0},
         '{4'b0000,  3, 4'b0000, 0, 0, 0},
         '{4'b1000,  3, 4'b0000, 0, 0, 0},
         '{4'b0000,  3, 4'b0000, 0, 0, 0},
         '{4'b1000,  2, 4'b0000, 0, 0, 0},
         '{4'b1000, 29, 4'b1000, 1, 0, 0},
         '{4'b0000, 20, 4'b0000, 0, 1, 2}
      };
      model_reset();
      repeat (3) reset_cycle();
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         sp = 0; sr = 0; srp = 0;
         btn_a = tbl[i].btn;
         repeat (tbl[i].cycles) cycle();
         chk($sformatf("seg%0d_level", i), lvl_a, tbl[i].lvl);
         chk($sformatf("seg%0d_presses", i), sp, tbl[i].prs);
         chk($sformatf("seg%0d_releases", i), sr, tbl[i].rel);
         chk($sformatf("seg%0d_repeats", i), srp, tbl[i].rep);
      end

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(5) == 0) begin
            j = $urandom_range(3);
            btn_a[j] = ~btn_a[j];
         end
         if ($urandom_range(5) == 0) begin
            j = $urandom_range(3);
            btn_b[j] = ~btn_b[j];
         end
         cycle();
      end

      // reset while ch0 is auto-repeating, button kept held across it
      btn_a = 4'h0;
      btn_b = 4'hF;
      repeat (30) cycle();
      btn_a = 4'b0001;
      repeat (60) cycle();
      chk("pre_rst_level", lvl_a, 4'b0001);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_a", {lvl_a, prs_a, rel_a, rep_a}, 16'h0);
      chk("rst_async_b", {lvl_b, prs_b, rel_b, rep_b}, 16'h0);
      model_reset();
      repeat (3) reset_cycle();
      rst_n = 1'b1;
      at = -1;
      cnt_rel = 0;
      sp = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (prs_a[0] && at < 0) at = i;
         cnt_rel += $countones(rel_a);
      end
      chk("rst_press_cycle", at, 11);
      chk("rst_press_count", sp, 1);
      chk("rst_release_count", cnt_rel, 0);

      // active-low instance: two channels pressed together
      btn_b = 4'b1010;
      got = 4'h0;
      for (int i = 0; i < 30 && got == 4'h0; i++) begin
         cycle();
         got = prs_b;
      end
      chk("simul_press_b", got, 4'b0101);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
